// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction ROM
// and hands one buffered instruction at a time to the decoder over valid/ready.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | out of reset, no fetch until start_i
//   RUN   | fetching one word per cycle whenever the output slot is free
//   HALT  | ROM returned HALT_OPCODE; waits for a branch to resume
module inst_fetch #(
  parameter int unsigned      ADDR_W      = 8,
  parameter int unsigned      INST_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = 8'h00,
  parameter logic [INST_W-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] address_o,
  input  logic [INST_W-1:0] instruction_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  logic transfer;
  logic slot_free;

  assign transfer  = valid_q & inst_ready_i;
  assign slot_free = ~valid_q | transfer;

  // State register with synchronous reset that overrides everything
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

  // Next-state, fetch and handshake logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    halted_d  = halted_q;
    // A consumed instruction empties the slot unless something refills it below;
    // this also lets a pending word drain while halted.
    valid_d   = transfer ? 1'b0 : valid_q;

    unique case (state_q)
      IDLE: begin
        // branch_i is deliberately ignored here, including alongside start_i
        if (start_i) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (branch_i) begin
          // Current ROM word belongs to the wrong path; drop it and any held word
          pc_d    = branch_target_i;
          valid_d = 1'b0;
        end else if (slot_free && (instruction_i == HALT_OPCODE)) begin
          // PC stays on the halt word so address_o reports where we stopped
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (slot_free) begin
          inst_d    = instruction_i;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + ADDR_W'(1);
        end
      end

      HALT: begin
        if (branch_i) begin
          pc_d     = branch_target_i;
          halted_d = 1'b0;
          state_d  = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign address_o    = pc_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = valid_q;
  assign halted_o     = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a small combinational ROM model.
module tb_inst_fetch;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       start_i;
  logic [7:0] address_o;
  logic [7:0] instruction_i;
  logic [7:0] inst_o;
  logic [7:0] inst_pc_o;
  logic       inst_valid_o;
  logic       inst_ready_i;
  logic       branch_i;
  logic [7:0] branch_target_i;
  logic       halted_o;

  int n_vec = 0;
  int n_err = 0;

  inst_fetch dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .start_i        (start_i),
    .address_o      (address_o),
    .instruction_i  (instruction_i),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .inst_valid_o   (inst_valid_o),
    .inst_ready_i   (inst_ready_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .halted_o       (halted_o)
  );

  always #5 clk_i = ~clk_i;

  // Program ROM; unmapped addresses return the halt word
  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'd0:    rom = 8'hC0;
      8'd1:    rom = 8'hC2;
      8'd2:    rom = 8'hC3;
      8'd3:    rom = 8'h11;
      8'd4:    rom = 8'h42;
      8'd5:    rom = 8'h55;
      8'd6:    rom = 8'h66;
      8'd7:    rom = 8'h77;
      8'd8:    rom = 8'h88;
      8'd9:    rom = 8'h99;
      8'd10:   rom = 8'hAA;
      8'd11:   rom = 8'hF0;
      8'd12:   rom = 8'hBB;
      8'd13:   rom = 8'h70;
      8'hFF:   rom = 8'h5A;
      default: rom = 8'hFF;
    endcase
  endfunction

  assign instruction_i = rom(address_o);

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string tag, input logic [7:0] pc);
    chk({tag, "_valid"}, {7'd0, inst_valid_o}, 8'd1);
    chk({tag, "_inst"},  inst_o,               rom(pc));
    chk({tag, "_pc"},    inst_pc_o,            pc);
  endtask

  initial begin
    rst_n_i         = 1'b0;
    start_i         = 1'b0;
    inst_ready_i    = 1'b1;
    branch_i        = 1'b0;
    branch_target_i = 8'h00;
    step();
    step();

    // Reset state
    chk("rst_addr",   address_o,             8'h00);
    chk("rst_valid",  {7'd0, inst_valid_o},  8'd0);
    chk("rst_halted", {7'd0, halted_o},      8'd0);
    chk("rst_inst",   inst_o,                8'h00);
    chk("rst_ipc",    inst_pc_o,             8'h00);

    // Straight-line run to the halt word
    rst_n_i = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("start_valid", {7'd0, inst_valid_o}, 8'd0);
    chk("start_addr",  address_o,            8'h00);
    for (int i = 0; i < 14; i++) begin
      step();
      chk_inst("run", 8'(i));
    end
    chk("pre_halt_addr", address_o, 8'd14);
    step();
    chk("halt_flag",  {7'd0, halted_o},     8'd1);
    chk("halt_addr",  address_o,            8'd14);
    chk("halt_valid", {7'd0, inst_valid_o}, 8'd0);

    // start_i is ignored while halted
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    chk("halt_start_flag", {7'd0, halted_o},     8'd1);
    chk("halt_start_addr", address_o,            8'd14);
    chk("halt_start_vld",  {7'd0, inst_valid_o}, 8'd0);

    // Branch out of HALT to 3
    branch_i        = 1'b1;
    branch_target_i = 8'h03;
    step();
    branch_i = 1'b0;
    chk("unhalt_flag", {7'd0, halted_o}, 8'd0);
    chk("unhalt_addr", address_o,        8'h03);
    step();
    chk_inst("unhalt", 8'd3);
    for (int i = 4; i <= 12; i++) begin
      step();
      chk_inst("run2", 8'(i));
    end
    chk("pre_br_addr", address_o, 8'd13);

    // Branch at 13 to 0x0B, while @12 is being transferred
    branch_i        = 1'b1;
    branch_target_i = 8'h0B;
    step();
    branch_i = 1'b0;
    chk("br_bubble", {7'd0, inst_valid_o}, 8'd0);
    chk("br_addr",   address_o,            8'h0B);
    step();
    chk_inst("br_tgt", 8'd11);

    // Wrap through 0xFF
    branch_i        = 1'b1;
    branch_target_i = 8'hFF;
    step();
    branch_i = 1'b0;
    chk("wrap_bubble", {7'd0, inst_valid_o}, 8'd0);
    step();
    chk_inst("wrap_ff", 8'hFF);
    chk("wrap_addr", address_o, 8'h00);
    for (int i = 0; i <= 4; i++) begin
      step();
      chk_inst("wrap_run", 8'(i));
    end

    // Backpressure while 0x42@4 is presented
    inst_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_inst("stall", 8'd4);
      chk("stall_addr", address_o, 8'd5);
    end
    inst_ready_i = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      step();
      chk_inst("resume", 8'(i));
    end

    // Reset mid-run at @7
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    chk("mrst_addr",   address_o,            8'h00);
    chk("mrst_valid",  {7'd0, inst_valid_o}, 8'd0);
    chk("mrst_halted", {7'd0, halted_o},     8'd0);
    chk("mrst_inst",   inst_o,               8'h00);
    step();
    chk("idle_addr",  address_o,            8'h00);
    chk("idle_valid", {7'd0, inst_valid_o}, 8'd0);

    // Branch ignored in IDLE
    branch_i        = 1'b1;
    branch_target_i = 8'h09;
    step();
    chk("idle_br_addr",  address_o,            8'h00);
    chk("idle_br_valid", {7'd0, inst_valid_o}, 8'd0);

    // start and branch together: start wins, branch dropped
    start_i = 1'b1;
    step();
    start_i  = 1'b0;
    branch_i = 1'b0;
    chk("sb_addr",  address_o,            8'h00);
    chk("sb_valid", {7'd0, inst_valid_o}, 8'd0);
    step();
    chk_inst("sb_first", 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
